// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Load-use, branch-operand and MDU-busy stalls plus MDU start/busy sequencing.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    output logic        Stall_PC,
    output logic        Stall_D,
    output logic        Clr_E,
    output logic        MD_Start,
    output logic [1:0]  MD_Op,
    output logic        MD_Busy,
    output logic [31:0] Stall_Cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] MULT_N = 4'(MULT_CYC);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

    logic [5:0] op_d, op_e, op_m;
    logic [5:0] funct_d, funct_e;
    logic [4:0] rs_d, rt_d;
    logic [4:0] rt_e, rd_e;
    logic [4:0] rt_m;

    assign op_d    = IR_D[31:26];
    assign rs_d    = IR_D[25:21];
    assign rt_d    = IR_D[20:16];
    assign funct_d = IR_D[5:0];
    assign op_e    = IR_E[31:26];
    assign rt_e    = IR_E[20:16];
    assign rd_e    = IR_E[15:11];
    assign funct_e = IR_E[5:0];
    assign op_m    = IR_M[31:26];
    assign rt_m    = IR_M[20:16];

    logic unused_bits;
    assign unused_bits = ^{IR_D[15:6], IR_E[25:21], IR_E[10:6],
                           IR_M[25:21], IR_M[15:0]};

    function automatic logic is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    logic [0:0] state;
    logic [3:0] cnt;
    logic       load_e, load_m, load_use;
    logic       br_d, br_rt, br_hazard;
    logic       md_d, md_e, md_hazard;
    logic       stall;
    logic [4:0] wr_dst;

    assign load_e = is_load(op_e);
    assign load_m = is_load(op_m);

    // Destination 0 doubles as "no ALU write"; jal is deliberately absent.
    always_comb begin
        wr_dst = 5'd0;
        if (op_e == 6'h00 &&
            !(funct_e inside {6'h08, 6'h11, 6'h13, [6'h18:6'h1B]}))
            wr_dst = rd_e;
        else if (op_e inside {[6'h08:6'h0F]})
            wr_dst = rt_e;
    end

    assign load_use = load_e && rt_e != 5'd0 &&
                      (rt_e == rs_d || rt_e == rt_d);

    assign br_rt = op_d == 6'h04 || op_d == 6'h05;
    assign br_d  = br_rt ||
                   (op_d == 6'h00 && (funct_d == 6'h08 || funct_d == 6'h09));

    assign br_hazard = br_d && (
        (wr_dst != 5'd0 &&
         (wr_dst == rs_d || (br_rt && wr_dst == rt_d))) ||
        (load_m && rt_m != 5'd0 &&
         (rt_m == rs_d || (br_rt && rt_m == rt_d))));

    assign md_d = op_d == 6'h00 &&
                  funct_d inside {[6'h10:6'h13], [6'h18:6'h1B]};
    assign md_e = op_e == 6'h00 && funct_e inside {[6'h18:6'h1B]};

    assign MD_Start  = Reset && state == IDLE && md_e;
    assign MD_Op     = funct_e[1:0];
    assign MD_Busy   = state == BUSY;
    assign md_hazard = md_d && (MD_Start || MD_Busy);

    assign stall    = Reset && (load_use || br_hazard || md_hazard);
    assign Stall_PC = stall;
    assign Stall_D  = stall;
    assign Clr_E    = stall;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (MD_Start) begin
            state <= BUSY;
            cnt   <= funct_e[1] ? DIV_N : MULT_N;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
                state <= IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            Stall_Cnt <= 32'd0;
        else if (stall && Stall_Cnt != 32'hFFFF_FFFF)
            Stall_Cnt <= Stall_Cnt + 32'd1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, MDU sequencing, async reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_hazard_ctrl;

    logic        Clk;
    logic        Reset;
    logic [31:0] IR_D, IR_E, IR_M;
    logic        Stall_PC, Stall_D, Clr_E;
    logic        MD_Start, MD_Busy;
    logic [1:0]  MD_Op;
    logic [31:0] Stall_Cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW_8_9  = 32'h8D28_0000;
    localparam logic [31:0] ADD_10  = 32'h010B_5020;
    localparam logic [31:0] ADDU_4  = 32'h00A6_2021;
    localparam logic [31:0] BEQ_4   = 32'h1080_0003;
    localparam logic [31:0] LW_4_5  = 32'h8CA4_0000;
    localparam logic [31:0] DIV_23  = 32'h0043_001A;
    localparam logic [31:0] MFLO_7  = 32'h0000_3812;
    localparam logic [31:0] MULT_23 = 32'h0043_0018;
    localparam logic [31:0] ADDU_0  = 32'h00A6_0021;
    localparam logic [31:0] BEQ_0   = 32'h1000_0003;
    localparam logic [31:0] LW_0_5  = 32'h8CA0_0000;
    localparam logic [31:0] ADD_00  = 32'h0000_5020;
    localparam logic [31:0] JAL     = 32'h0C00_0010;
    localparam logic [31:0] JR_31   = 32'h03E0_0008;

    pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IR_D     (IR_D),
        .IR_E     (IR_E),
        .IR_M     (IR_M),
        .Stall_PC (Stall_PC),
        .Stall_D  (Stall_D),
        .Clr_E    (Clr_E),
        .MD_Start (MD_Start),
        .MD_Op    (MD_Op),
        .MD_Busy  (MD_Busy),
        .Stall_Cnt(Stall_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_pc"}, {31'd0, Stall_PC}, {31'd0, exp});
        chk({tag, "_d"},  {31'd0, Stall_D},  {31'd0, exp});
        chk({tag, "_clr"}, {31'd0, Clr_E},   {31'd0, exp});
    endtask

    // An MDU op reaching E while the unit is busy would be a stimulus bug.
    task automatic drive(input logic [31:0] d, input logic [31:0] e,
                         input logic [31:0] m);
        logic md_in_e;
        @(negedge Clk);
        IR_D = d;
        IR_E = e;
        IR_M = m;
        #1;
        md_in_e = e[31:26] == 6'h00 && e[5:0] inside {[6'h18:6'h1B]};
        if (md_in_e)
            chk("mdu_in_e_while_busy", {31'd0, MD_Busy}, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int stall_run;
        Reset = 1'b0;
        IR_D  = NOP;
        IR_E  = NOP;
        IR_M  = NOP;

        // Reset holds all outputs low even with a live hazard on the inputs.
        drive(ADD_10, LW_8_9, NOP);
        chk_stall("rst_stall", 1'b0);
        chk("rst_busy", {31'd0, MD_Busy}, 32'd0);
        chk("rst_cnt", Stall_Cnt, 32'd0);
        drive(MFLO_7, NOP, NOP);
        IR_E = DIV_23;
        #1;
        chk("rst_start", {31'd0, MD_Start}, 32'd0);
        IR_E = NOP;
        @(negedge Clk);
        Reset = 1'b1;

        // Load-use
        drive(ADD_10, LW_8_9, NOP);
        chk_stall("lu", 1'b1);
        chk("lu_cnt0", Stall_Cnt, 32'd0);
        drive(ADD_10, NOP, LW_8_9);
        chk_stall("lu_after", 1'b0);
        chk("lu_cnt1", Stall_Cnt, 32'd1);

        // Branch after ALU writer
        drive(BEQ_4, ADDU_4, NOP);
        chk_stall("br_alu", 1'b1);
        drive(BEQ_4, NOP, ADDU_4);
        chk_stall("br_alu_after", 1'b0);
        chk("br_alu_cnt", Stall_Cnt, 32'd2);

        // Branch after load: load-use then load_M
        drive(BEQ_4, LW_4_5, NOP);
        chk_stall("br_ld_e", 1'b1);
        drive(BEQ_4, NOP, LW_4_5);
        chk_stall("br_ld_m", 1'b1);
        drive(BEQ_4, NOP, NOP);
        chk_stall("br_ld_after", 1'b0);
        chk("br_ld_cnt", Stall_Cnt, 32'd4);

        // div followed by mflo
        drive(MFLO_7, DIV_23, NOP);
        chk("div_start", {31'd0, MD_Start}, 32'd1);
        chk("div_op", {30'd0, MD_Op}, 32'd2);
        chk("div_busy0", {31'd0, MD_Busy}, 32'd0);
        chk_stall("div_t", 1'b1);
        stall_run = 1;
        for (int k = 1; k <= 11; k++) begin
            drive(MFLO_7, NOP, NOP);
            chk($sformatf("div_busy%0d", k), {31'd0, MD_Busy},
                (k <= 10) ? 32'd1 : 32'd0);
            chk($sformatf("div_nostart%0d", k), {31'd0, MD_Start}, 32'd0);
            if (Stall_PC)
                stall_run++;
        end
        chk("div_stall_len", stall_run, 32'd11);
        chk_stall("div_issue", 1'b0);
        chk("div_cnt", Stall_Cnt, 32'd15);

        // No false hazards
        drive(BEQ_0, ADDU_0, NOP);
        chk_stall("zero_wr", 1'b0);
        drive(ADD_00, LW_0_5, NOP);
        chk_stall("zero_ld", 1'b0);
        drive(JR_31, JAL, NOP);
        chk_stall("jal_e", 1'b0);
        drive(ADDU_4, MULT_23, NOP);
        chk_stall("mult_addu", 1'b0);
        chk("mult_start", {31'd0, MD_Start}, 32'd1);
        chk("mult_op", {30'd0, MD_Op}, 32'd0);
        drive(NOP, NOP, NOP);
        chk("mult_busy1", {31'd0, MD_Busy}, 32'd1);
        drive(NOP, NOP, NOP);
        chk("mult_busy2", {31'd0, MD_Busy}, 32'd1);
        chk("nofalse_cnt", Stall_Cnt, 32'd15);

        // Async reset mid-BUSY with cnt = 3, between clock edges
        drive(NOP, NOP, NOP);
        chk("pre_rst_busy", {31'd0, MD_Busy}, 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, MD_Busy}, 32'd0);
        chk("arst_cnt", Stall_Cnt, 32'd0);
        #1;
        Reset = 1'b1;

        // Fresh mult busies for exactly 5 cycles
        drive(MFLO_7, MULT_23, NOP);
        chk("re_start", {31'd0, MD_Start}, 32'd1);
        chk("re_op", {30'd0, MD_Op}, 32'd0);
        chk_stall("re_stall", 1'b1);
        busy_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            drive(NOP, NOP, NOP);
            chk($sformatf("re_busy%0d", k), {31'd0, MD_Busy},
                (k <= 5) ? 32'd1 : 32'd0);
            if (MD_Busy)
                busy_cnt++;
        end
        chk("re_busy_len", busy_cnt, 32'd5);
        chk("re_cnt", Stall_Cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and stall controller for the 5-stage MIPS pipeline.
- Decodes IR_D, IR_E and IR_M and produces three controls:
  - a hold for the PC and IF/ID registers;
  - a clear (bubble insert) for ID/EX;
  - start/busy sequencing for the multi-cycle multiply/divide unit (MDU).
- EX/MEM and MEM/WB always advance; they are never stalled by this block.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (range 1..15).
- DIV_CYC, 10, busy cycles for div/divu (range 1..15).

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low. 0 = reset.
- IR_D  in  32  instruction in decode.
- IR_E  in  32  instruction in execute.
- IR_M  in  32  instruction in memory.
- Stall_PC  out  1  1 = PC holds its value.
- Stall_D  out  1  1 = IF/ID register holds.
- Clr_E  out  1  1 = ID/EX loads a NOP (all zeros) on the next edge.
- MD_Start  out  1  1-cycle pulse that launches the MDU op in E.
- MD_Op  out  2  operation launched: 0 mult, 1 multu, 2 div, 3 divu. Valid with MD_Start.
- MD_Busy  out  1  MDU is computing.
- Stall_Cnt  out  32  count of stalled cycles.

Behaviour:
- Decode fields:
  - op = IR[31:26], rs = IR[25:21], rt = IR[20:16], rd = IR[15:11], funct = IR[5:0].
  - Register 0 never causes a hazard.
- load_E: IR_E op is 0x20, 0x21, 0x23, 0x24 or 0x25. Destination is rt.
- load_M: the same decode applied to IR_M.
- wr_E (ALU writer in E), destination reg:
  - op 0 with rd != 0 and funct not in {0x08, 0x11, 0x13, 0x18..0x1B}: destination rd.
  - op 0x08..0x0F: destination rt.
  - jal: never a hazard (PC+8 is forwarded).
- Hazard terms:
  - load_use = load_E && rt_E != 0 && (rt_E == rs_D || rt_E == rt_D). Conservative: every D instruction is treated as reading both rs and rt.
  - br_D = (op_D 0x04 or 0x05; sources rs, rt) or (op_D 0 with funct 0x08 or 0x09; source rs only).
  - br_hazard = br_D && ((wr_E dest matches a D source) || (load_M rt matches a D source)).
  - md_D = op_D 0 with funct in {0x10..0x13, 0x18..0x1B}.
  - md_hazard = md_D && (MD_Start || MD_Busy).
- Stall output:
  - Stall = load_use | br_hazard | md_hazard.
  - Stall_PC = Stall_D = Clr_E = Stall, combinational, same cycle.
  - While Reset = 0, all three are forced to 0.
- MDU FSM, states IDLE and BUSY, 4-bit down-counter cnt:
  - MD_Start = IDLE && IR_E is op 0 with funct 0x18..0x1B. Combinational.
  - MD_Op = funct_E[1:0].
  - Start in cycle t: the edge ending t loads cnt = MULT_CYC (funct 0x18/0x19) or DIV_CYC (0x1A/0x1B), state -> BUSY.
  - Each following edge decrements cnt. At the edge where cnt is 1: cnt -> 0, state -> IDLE.
  - MD_Busy = (state == BUSY), asserted for cycles t+1..t+N exactly.
  - An md_D instruction stalls through t..t+N and issues at t+N+1.
  - An MDU op in IR_E while BUSY is impossible by construction. The bench asserts this never happens. RTL ignores it: no restart, no MD_Start.
- Stall_Cnt:
  - Increments on each rising edge where Stall = 1.
  - Saturates at 0xFFFFFFFF.
- Reset (async, Reset = 0): state IDLE, cnt 0, Stall_Cnt 0, MD_Busy 0, MD_Start 0, Stall_PC/Stall_D/Clr_E 0.
  - Reset mid-BUSY aborts the count immediately.
  - After release, the first rising edge behaves as normal operation.
- Simultaneous hazards: OR-combined. They yield a single stall cycle per evaluation and increment Stall_Cnt by 1.

Test Plan:
- Load-use: IR_E = lw $8,0($9) (0x8D280000), IR_D = add $10,$8,$11 -> Stall_PC = Stall_D = Clr_E = 1 for exactly 1 cycle; Stall_Cnt 0 -> 1.
- Branch after ALU: IR_E = addu $4,$5,$6, IR_D = beq $4,$0,x -> 1-cycle stall. Next cycle the addu is in M and IR_E is a NOP -> no stall.
- Branch after load: IR_E = lw $4, IR_D = beq $4,$0 -> stall 1 cycle (load_use), then stall 1 more cycle (load_M) -> 2 total; Stall_Cnt = 2.
- MDU sequencing: IR_E = div $2,$3 with default params -> MD_Start = 1 and MD_Op = 2 for one cycle; MD_Busy high for 10 cycles. Follow-up mflo in D stalls 11 cycles and issues on the 12th.
- No false hazards: writes to/reads of $0, jal in E, and mult followed by unrelated addu -> Stall stays 0 throughout.
- Async reset: drive Reset = 0 between edges mid-BUSY (cnt = 3) -> MD_Busy = 0 and Stall_Cnt = 0 immediately, with no clock edge. After release, a new mult busies for exactly 5 cycles.
